// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard interface: ID operand/destination info and forwarding-stage
// status go in, forwarding selects and stall/bubble controls come back.
interface hazard_scoreboard_if #(
  parameter int NUM_FWD = 3,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 4
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic                       id_issue;
  logic [NUM_SRC*REG_AW-1:0]  id_src;
  logic [NUM_SRC-1:0]         id_src_used;
  logic                       id_long;
  logic [REG_AW-1:0]          id_dst;
  logic [LAT_W-1:0]           id_lat;
  logic [NUM_FWD-1:0]         fwd_wr;
  logic [NUM_FWD*REG_AW-1:0]  fwd_rd;
  logic [NUM_FWD-1:0]         fwd_rdy;
  logic                       freeze;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall_id;
  logic                       bubble_ex;
  logic [31:0]                stall_cnt;

  modport master (
    output id_issue, id_src, id_src_used, id_long, id_dst, id_lat,
           fwd_wr, fwd_rd, fwd_rdy, freeze, flush,
    input  fwd_sel, stall_id, bubble_ex, stall_cnt
  );

  modport slave (
    input  id_issue, id_src, id_src_used, id_long, id_dst, id_lat,
           fwd_wr, fwd_rd, fwd_rdy, freeze, flush,
    output fwd_sel, stall_id, bubble_ex, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside the decode stage: per-operand forwarding selects, a
// per-register countdown scoreboard for long-latency ops, and the ID stall.
module hazard_scoreboard #(
  parameter int NUM_FWD = 3,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int SEL_W    = $clog2(NUM_FWD + 1);
  localparam int NUM_REGS = 2 ** REG_AW;

  logic [LAT_W-1:0]         cnt [NUM_REGS];
  logic [NUM_SRC*SEL_W-1:0] sel_vec;
  logic [NUM_SRC-1:0]       raw_vec;
  logic                     waw;
  logic                     stall;
  logic                     accept;
  logic [LAT_W-1:0]         load_val;
  logic [31:0]              stall_cnt_q;

  genvar s;
  generate
    for (s = 0; s < NUM_SRC; s++) begin : g_src
      logic [REG_AW-1:0] r;
      logic [SEL_W-1:0]  sel;
      logic              match_rdy;

      assign r = bus.id_src[s*REG_AW +: REG_AW];

      // Scan oldest to youngest so the youngest matching stage wins, ready or not
      always_comb begin
        sel       = '0;
        match_rdy = 1'b1;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
          if (r != '0 && bus.fwd_wr[i] && bus.fwd_rd[i*REG_AW +: REG_AW] == r) begin
            sel       = SEL_W'(i + 1);
            match_rdy = bus.fwd_rdy[i];
          end
        end
      end

      assign sel_vec[s*SEL_W +: SEL_W] = sel;
      assign raw_vec[s] = bus.id_src_used[s] && (r != '0) &&
                          (!match_rdy || cnt[r] != '0);
    end
  endgenerate

  assign waw      = bus.id_long && (bus.id_dst != '0) && (cnt[bus.id_dst] != '0);
  assign stall    = bus.id_issue && ((|raw_vec) || waw);
  assign accept   = bus.id_issue && bus.id_long && !stall && !bus.freeze &&
                    !bus.flush && (bus.id_dst != '0);
  assign load_val = (bus.id_lat == '0) ? LAT_W'(1) : bus.id_lat;

  assign bus.fwd_sel   = sel_vec;
  assign bus.stall_id  = stall;
  assign bus.bubble_ex = stall && !bus.freeze;
  assign bus.stall_cnt = stall_cnt_q;

  // Scoreboard: flush wipes, freeze holds, otherwise load on issue and count down
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (bus.flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (!bus.freeze) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (accept && REG_AW'(r) == bus.id_dst) cnt[r] <= load_val;
        else if (cnt[r] != '0)                 cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  // Saturating count of non-frozen hazard-stall cycles; survives flush
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else if (stall && !bus.freeze && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end
endmodule
